// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster sequencer plus a one-window-per-frame game-state update arbiter.
// Build option PIX_DIV_EN: pixel tick derived from clk divided by CLK_DIV (else clk is the pixel clock).
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
`ifdef PIX_DIV_EN
  ,
  parameter int CLK_DIV  = 2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pixel,
  output logic [8:0] line,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_en,
  output logic       frame_tick,
  input  logic       upd_req,
  output logic       upd_gnt,
  input  logic       upd_done,
  output logic       upd_late
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} upd_state_t;

  logic       tick;
  logic [9:0] vcnt_reg;
  logic [9:0] pixel_next, vcnt_next;
  logic       h_wrap, v_wrap, frame_start, frame_wrap, vblank;
  upd_state_t state_reg, state_next;
  logic       served_reg, served_next, late_next;

`ifdef PIX_DIV_EN
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div_reg <= '0;
    else if (div_reg == DIV_LAST) div_reg <= '0;
    else                       div_reg <= div_reg + 1'b1;
  end

  assign tick = (div_reg == DIV_LAST);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    h_wrap      = (pixel == H_LAST);
    v_wrap      = (vcnt_reg == V_LAST);
    pixel_next  = h_wrap ? 10'd0 : pixel + 10'd1;
    vcnt_next   = h_wrap ? (v_wrap ? 10'd0 : vcnt_reg + 10'd1) : vcnt_reg;
    frame_start = tick && h_wrap && (vcnt_next == V_ACT);
    frame_wrap  = tick && h_wrap && v_wrap;
    vblank      = (vcnt_reg >= V_ACT);
  end

  // Sync/blank/line are registered from the next-count values so they line up with pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel      <= H_LAST;
      vcnt_reg   <= V_LAST;
      line       <= 9'h1FF;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      pix_en     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix_en     <= tick;
      frame_tick <= frame_start;
      if (tick) begin
        pixel    <= pixel_next;
        vcnt_reg <= vcnt_next;
        line     <= (vcnt_next < V_ACT) ? vcnt_next[8:0] : 9'h1FF;
        hsync    <= !((pixel_next >= HS_BEG) && (pixel_next < HS_END));
        vsync    <= !((vcnt_next >= VS_BEG) && (vcnt_next < VS_END));
        video_on <= (pixel_next < H_ACT) && (vcnt_next < V_ACT);
      end
    end
  end

  // A grant is never opened on the wrap edge, so the window cannot overlap active video.
  always_comb begin
    state_next  = state_reg;
    served_next = served_reg;
    late_next   = 1'b0;
    if (frame_start) served_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (upd_req) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!upd_req)                                     state_next = S_IDLE;
        else if (vblank && !served_reg && !frame_wrap)    state_next = S_GRANT;
      end
      S_GRANT: begin
        if (upd_done) begin
          state_next  = S_IDLE;
          served_next = 1'b1;
        end else if (frame_wrap) begin
          state_next  = S_IDLE;
          served_next = 1'b1;
          late_next   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      served_reg <= 1'b0;
      upd_gnt    <= 1'b0;
      upd_late   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      served_reg <= served_next;
      upd_gnt    <= (state_next == S_GRANT);
      upd_late   <= late_next;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: randomized update traffic on a shrunk raster, checked every clk against
// an arithmetic reference (position derived from tick count, update rules applied per edge).
module tb_vga_scan_ctrl;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
`ifdef PIX_DIV_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int FRAME_CLKS = HT * VT * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_done = 1'b0;
  logic [9:0] pixel;
  logic [8:0] line;
  logic       hsync, vsync, video_on, pix_en, frame_tick, upd_gnt, upd_late;

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
`ifdef PIX_DIV_EN
    , .CLK_DIV(D)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pix_en(pix_en), .frame_tick(frame_tick), .upd_req(upd_req),
    .upd_gnt(upd_gnt), .upd_done(upd_done), .upd_late(upd_late)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: clk edges since release, ticks seen, derived raster position, update status.
  int k, n, m_pix, m_v;
  bit m_tick, m_ft, m_gnt, m_pend, m_served, m_late;
  int hold_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void compute_pos();
    if (n == 0) begin
      m_pix = HT - 1;
      m_v   = VT - 1;
    end else begin
      m_pix = (n - 1) % HT;
      m_v   = ((n - 1) / HT) % VT;
    end
  endfunction

  function automatic void model_reset();
    k = 0; n = 0;
    m_tick = 0; m_ft = 0; m_gnt = 0; m_pend = 0; m_served = 0; m_late = 0;
    compute_pos();
  endfunction

  function automatic void model_edge(input bit req, input bit done);
    bit vblank_prev, g, p, s, wrap;
    vblank_prev = (m_v >= VA);
    g = m_gnt; p = m_pend; s = m_served;
    k++;
    m_tick = (k % D == 0);
    if (m_tick) n++;
    compute_pos();
    wrap   = m_tick && m_pix == 0 && m_v == 0;
    m_ft   = m_tick && m_pix == 0 && m_v == VA;
    m_late = 0;
    if (m_ft) m_served = 0;
    if (g) begin
      if (done) begin
        m_gnt = 0; m_pend = 0; m_served = 1;
      end else if (wrap) begin
        m_gnt = 0; m_pend = 0; m_served = 1; m_late = 1;
      end
    end else if (p) begin
      if (!req) m_pend = 0;
      else if (vblank_prev && !s && !wrap) m_gnt = 1;
    end else if (req) begin
      m_pend = 1;
    end
  endfunction

  task automatic check_all();
    check("pixel", pixel, m_pix);
    check("line", line, (m_v < VA) ? m_v : 'h1FF);
    check("hsync", hsync, !(m_pix >= HA + HF && m_pix < HA + HF + HS));
    check("vsync", vsync, !(m_v >= VA + VF && m_v < VA + VF + VS));
    check("video_on", video_on, (m_pix < HA) && (m_v < VA));
    check("pix_en", pix_en, m_tick);
    check("frame_tick", frame_tick, m_ft);
    check("upd_gnt", upd_gnt, m_gnt);
    check("upd_late", upd_late, m_late);
    check("gnt_in_video", upd_gnt & video_on, 0);
  endtask

  task automatic drive_inputs();
    bit next_wrap;
    next_wrap = ((k + 1) % D == 0) && m_pix == HT - 1 && m_v == VT - 1;
    if (m_ft) hold_mode = $urandom_range(0, 2);
    if (m_gnt) begin
      case (hold_mode)
        0:       upd_done = ($urandom_range(0, 99) < 4);
        1:       upd_done = 1'b0;
        default: upd_done = next_wrap;
      endcase
    end else begin
      upd_done = ($urandom_range(0, 199) == 0);
    end
    if (upd_req) upd_req = !($urandom_range(0, 99) == 0);
    else         upd_req = ($urandom_range(0, 99) < 6);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(upd_req, upd_done);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    hold_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 12 * FRAME_CLKS; i++) begin
      step();
      drive_inputs();
    end

    // Open a window and then pull reset while it is held.
    upd_req = 1'b1;
    upd_done = 1'b0;
    hold_mode = 1;
    for (int i = 0; i < 3 * FRAME_CLKS && !m_gnt; i++) step();
    check("grant_reached", m_gnt, 1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", upd_gnt, 0);
    check("rst_late", upd_late, 0);
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
      step();
      drive_inputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
